// File: rtl/prbs_ctrl_pkg.sv
// Shared types and default widths for the PRBS run controller.
package prbs_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_SYNC,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int CNT_W_DEF = 32;
    localparam int ERR_W_DEF = 16;
endpackage

// File: rtl/prbs_sat_cnt.sv
// Clearable up-counter advanced on word strobes; SAT=1 holds at all-ones, SAT=0 wraps.
module prbs_sat_cnt #(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            q <= '0;
        else if (ce) begin
            if (clr)
                q <= '0;
            else if (inc && !(SAT && (&q)))
                q <= q + 1'b1;
        end
endmodule

// File: rtl/prbs_ber_ctrl.sv
// Run controller for the PRBS receive checker: arm, sync wait, counted run, pass/fail.
// Define PRBS_FIRST_ERR_EN to add FIRST_ERR / FE_VLD first-mismatch reporting.
module prbs_ber_ctrl
    import prbs_ctrl_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ERR_W    = ERR_W_DEF,
    parameter int ARM_CYC  = 4,
    parameter int SYNC_TMO = 4096
) (
    input  logic             REC_CLK,
    input  logic             RST,
    input  logic             CE3,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] RUN_LEN,
    input  logic [ERR_W-1:0] ERR_THR,
    input  logic             STRT_MTCH,
    input  logic             VALID,
    input  logic             MATCH,
    output logic             CHK_RST,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             TMO,
    output logic             LOST,
    output logic [CNT_W-1:0] WORD_CNT,
    output logic [ERR_W-1:0] ERR_CNT
`ifdef PRBS_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] FIRST_ERR,
    output logic             FE_VLD
`endif
);
    localparam int DW_MAX = (SYNC_TMO > ARM_CYC) ? SYNC_TMO : ARM_CYC;
    localparam int DW_W   = (DW_MAX > 1) ? $clog2(DW_MAX) : 1;
    localparam logic [DW_W-1:0] ARM_LAST = DW_W'(ARM_CYC - 1);
    localparam logic [DW_W-1:0] TMO_LAST = DW_W'(SYNC_TMO - 1);

    state_t           state, nxt;
    logic             start_req, abort_req, go_req, ab_req;
    logic             accept, in_chk, word_evt, err_evt, word_last, tmo_hit;
    logic [CNT_W-1:0] run_len_q, word_nxt;
    logic [ERR_W-1:0] err_thr_q;
    logic [DW_W-1:0]  dwell;
    logic             tmo_q, lost_q, pass_ok;
    logic             unused_strt;

    // Start-pattern detect is observed only through VALID, which follows it.
    assign unused_strt = STRT_MTCH;

    // Host pulses may land between strobes; hold them until the next CE3.
    always_ff @(posedge REC_CLK or posedge RST)
        if (RST) begin
            start_req <= 1'b0;
            abort_req <= 1'b0;
        end else if (CE3) begin
            start_req <= 1'b0;
            abort_req <= 1'b0;
        end else begin
            if (START) start_req <= 1'b1;
            if (ABORT) abort_req <= 1'b1;
        end

    assign go_req    = start_req | START;
    assign ab_req    = abort_req | ABORT;
    assign in_chk    = (state == ST_WAIT_SYNC) || (state == ST_RUN);
    assign accept    = CE3 && go_req && !ab_req && (state == ST_IDLE || state == ST_DONE);
    assign word_evt  = CE3 && in_chk && !ab_req && VALID;
    assign err_evt   = word_evt && !MATCH;
    assign word_nxt  = WORD_CNT + 1'b1;
    assign word_last = (word_nxt == run_len_q);
    assign tmo_hit   = (state == ST_WAIT_SYNC) && !VALID && (dwell == TMO_LAST);

    always_ff @(posedge REC_CLK or posedge RST)
        if (RST) state <= ST_IDLE;
        else     state <= nxt;

    always_comb begin
        nxt = state;
        if (CE3) begin
            case (state)
                ST_IDLE, ST_DONE:
                    if (go_req && !ab_req) nxt = ST_ARM;
                ST_ARM:
                    if (ab_req)                  nxt = ST_DONE;
                    else if (dwell == ARM_LAST)  nxt = ST_WAIT_SYNC;
                ST_WAIT_SYNC:
                    if (ab_req || tmo_hit)       nxt = ST_DONE;
                    else if (VALID)              nxt = word_last ? ST_DONE : ST_RUN;
                ST_RUN:
                    if (ab_req || !VALID || word_last) nxt = ST_DONE;
                default: nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        CHK_RST = 1'b1;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        case (state)
            ST_ARM:               BUSY = 1'b1;
            ST_WAIT_SYNC, ST_RUN: begin CHK_RST = 1'b0; BUSY = 1'b1; end
            ST_DONE:              DONE = 1'b1;
            default: ;
        endcase
    end

    // pass_ok marks a run that ended on its word count; the error threshold is applied at the output.
    always_ff @(posedge REC_CLK or posedge RST)
        if (RST) begin
            run_len_q <= '0;
            err_thr_q <= '0;
            tmo_q     <= 1'b0;
            lost_q    <= 1'b0;
            pass_ok   <= 1'b0;
        end else if (accept) begin
            run_len_q <= (RUN_LEN == '0) ? CNT_W'(1) : RUN_LEN;
            err_thr_q <= ERR_THR;
            tmo_q     <= 1'b0;
            lost_q    <= 1'b0;
            pass_ok   <= 1'b0;
        end else if (CE3 && !ab_req) begin
            if (tmo_hit)                   tmo_q   <= 1'b1;
            if (state == ST_RUN && !VALID) lost_q  <= 1'b1;
            if (word_evt && word_last)     pass_ok <= 1'b1;
        end

    assign PASS = (state == ST_DONE) && pass_ok && (ERR_CNT <= err_thr_q);
    assign TMO  = tmo_q;
    assign LOST = lost_q;

    prbs_sat_cnt #(.W(DW_W), .SAT(1'b0)) u_dwell (
        .clk(REC_CLK), .rst(RST), .ce(CE3), .clr(nxt != state), .inc(BUSY), .q(dwell)
    );

    prbs_sat_cnt #(.W(CNT_W), .SAT(1'b0)) u_word (
        .clk(REC_CLK), .rst(RST), .ce(CE3), .clr(accept), .inc(word_evt), .q(WORD_CNT)
    );

    prbs_sat_cnt #(.W(ERR_W), .SAT(1'b1)) u_err (
        .clk(REC_CLK), .rst(RST), .ce(CE3), .clr(accept), .inc(err_evt), .q(ERR_CNT)
    );

`ifdef PRBS_FIRST_ERR_EN
    always_ff @(posedge REC_CLK or posedge RST)
        if (RST) begin
            FIRST_ERR <= '0;
            FE_VLD    <= 1'b0;
        end else if (accept) begin
            FIRST_ERR <= '0;
            FE_VLD    <= 1'b0;
        end else if (err_evt && !FE_VLD) begin
            FIRST_ERR <= WORD_CNT;
            FE_VLD    <= 1'b1;
        end
`endif
endmodule

// File: tb/tb_prbs_ber_ctrl.sv
// Scoreboard bench for prbs_ber_ctrl: a mock checker plays a per-word plan, a run-level model predicts results.
module tb_prbs_ber_ctrl;
    localparam int CNT_W    = 32;
    localparam int ERR_W    = 4;
    localparam int ARM_CYC  = 4;
    localparam int SYNC_TMO = 4096;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;
    localparam int PLAN_N   = 1200;
    localparam int TMO_LAT  = 4 * (ARM_CYC + SYNC_TMO);

    typedef struct {
        int words;
        int errs;
        bit pass;
        bit tmo;
        bit lost;
        int first;
        bit fe;
    } exp_t;

    logic             REC_CLK = 1'b0;
    logic             RST = 1'b1, CE3 = 1'b0, START = 1'b0, ABORT = 1'b0;
    logic             STRT_MTCH = 1'b0, VALID = 1'b0, MATCH = 1'b0;
    logic [CNT_W-1:0] RUN_LEN = '0;
    logic [ERR_W-1:0] ERR_THR = '0;
    logic             CHK_RST, BUSY, DONE, PASS, TMO, LOST;
    logic [CNT_W-1:0] WORD_CNT;
    logic [ERR_W-1:0] ERR_CNT;
`ifdef PRBS_FIRST_ERR_EN
    logic [CNT_W-1:0] FIRST_ERR;
    logic             FE_VLD;
`endif

    exp_t sb[$];
    int   tests = 0, fails = 0;
    int   cyc = 0;
    int   k = 0;
    int   plan_d = 0;
    bit   plan_v[PLAN_N];
    bit   plan_m[PLAN_N];
    logic done_q = 1'b0;

    prbs_ber_ctrl #(.CNT_W(CNT_W), .ERR_W(ERR_W), .ARM_CYC(ARM_CYC), .SYNC_TMO(SYNC_TMO)) dut (
        .REC_CLK(REC_CLK), .RST(RST), .CE3(CE3), .START(START), .ABORT(ABORT),
        .RUN_LEN(RUN_LEN), .ERR_THR(ERR_THR), .STRT_MTCH(STRT_MTCH), .VALID(VALID), .MATCH(MATCH),
        .CHK_RST(CHK_RST), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TMO(TMO), .LOST(LOST),
        .WORD_CNT(WORD_CNT), .ERR_CNT(ERR_CNT)
`ifdef PRBS_FIRST_ERR_EN
        , .FIRST_ERR(FIRST_ERR), .FE_VLD(FE_VLD)
`endif
    );

    initial forever #3 REC_CLK = ~REC_CLK;
    always @(posedge REC_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic plan_clear();
        for (int i = 0; i < PLAN_N; i++) begin
            plan_v[i] = 1'b1;
            plan_m[i] = 1'b1;
        end
    endtask

    // Walk the word samples seen after the checker is released: d idle samples, then the plan.
    function automatic exp_t model(input int rl, input int thr, input int d, input int ab);
        exp_t e;
        int   target, j;
        e = '{default: 0};
        target = (rl == 0) ? 1 : rl;
        for (int s = 0; s < d + PLAN_N; s++) begin
            if (s == ab) return e;
            if (s < d) begin
                if (s == SYNC_TMO - 1) begin
                    e.tmo = 1'b1;
                    return e;
                end
            end else begin
                j = s - d;
                if (!plan_v[j]) begin
                    e.lost = 1'b1;
                    return e;
                end
                if (!plan_m[j]) begin
                    if (!e.fe) begin
                        e.fe    = 1'b1;
                        e.first = e.words;
                    end
                    if (e.errs < ERR_MAX) e.errs++;
                end
                e.words++;
                if (e.words == target) begin
                    e.pass = (e.errs <= thr);
                    return e;
                end
            end
        end
        return e;
    endfunction

    // Mock checker: strobe generator plus word playback once CHK_RST is released.
    initial begin : checker_mock
        int ph;
        int j;
        ph = 0;
        forever begin
            @(negedge REC_CLK);
            CE3 = (ph == 3);
            ph  = (ph + 1) % 4;
            if (RST || CHK_RST) begin
                k = 0;
                VALID = 1'b0;
                MATCH = 1'b0;
                STRT_MTCH = 1'b0;
            end else if (CE3) begin
                j = k - plan_d;
                STRT_MTCH = (j == 0);
                if (j < 0) begin
                    VALID = 1'b0;
                    MATCH = 1'b0;
                end else if (j < PLAN_N) begin
                    VALID = plan_v[j];
                    MATCH = plan_m[j];
                end else begin
                    VALID = 1'b1;
                    MATCH = 1'b1;
                end
                k++;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge REC_CLK);
            if (!RST && DONE && !done_q) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: DONE rose with no run pending");
                end else begin
                    e = sb.pop_front();
                    chk("word_cnt", WORD_CNT, e.words);
                    chk("err_cnt", ERR_CNT, e.errs);
                    chk("pass", PASS, e.pass);
                    chk("tmo", TMO, e.tmo);
                    chk("lost", LOST, e.lost);
`ifdef PRBS_FIRST_ERR_EN
                    chk("fe_vld", FE_VLD, e.fe);
                    if (e.fe) chk("first_err", FIRST_ERR, e.first);
`endif
                end
            end
            done_q = DONE && !RST;
        end
    end

    task automatic reset_checks();
        chk("rst_chk_rst", CHK_RST, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_pass", PASS, 0);
        chk("rst_tmo", TMO, 0);
        chk("rst_lost", LOST, 0);
        chk("rst_word_cnt", WORD_CNT, 0);
        chk("rst_err_cnt", ERR_CNT, 0);
`ifdef PRBS_FIRST_ERR_EN
        chk("rst_fe_vld", FE_VLD, 0);
`endif
    endtask

    task automatic wait_k(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge REC_CLK);
            #1;
            ok = (k == target);
        end
    endtask

    task automatic do_run(input int rl, input int thr, input int d, input int ab, output int lat);
        int t0, n;
        bit ok;
        RUN_LEN = CNT_W'(rl);
        ERR_THR = ERR_W'(thr);
        plan_d  = d;
        sb.push_back(model(rl, thr, d, ab));
        repeat ($urandom_range(1, 6)) @(negedge REC_CLK);
        START = 1'b1;
        t0 = cyc;
        @(negedge REC_CLK);
        START = 1'b0;
        n = 0;
        while (!BUSY && n < 3) begin
            @(negedge REC_CLK);
            n++;
        end
        chk("start_latency", BUSY && CHK_RST, 1);
        RUN_LEN = $urandom;               // already captured; must not matter now
        ERR_THR = ERR_W'($urandom);
        if (ab > 0) begin
            wait_k(ab, ok);
            chk("abort_point_reached", ok, 1);
            @(negedge REC_CLK);
            START = 1'b1;
            ABORT = 1'b1;
            @(negedge REC_CLK);
            START = 1'b0;
            ABORT = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge REC_CLK);
            ok = DONE;
        end
        lat = cyc - t0;
        chk("done_reached", ok, 1);
        if (!ok) begin
            RST = 1'b1;
            @(negedge REC_CLK);
            RST = 1'b0;
            sb.delete();
        end else if (ab > 0) begin
            repeat (12) @(negedge REC_CLK);
            chk("abort_start_dropped", DONE && !BUSY, 1);
        end
    endtask

    initial begin : stim
        int lat, rl, thr, d, ab, tgt, li;
        bit ok;
        plan_clear();
        RST = 1'b1;
        repeat (5) @(negedge REC_CLK);
        reset_checks();
        START = 1'b1;                     // pulse under reset must not leave a pending request
        @(negedge REC_CLK);
        START = 1'b0;
        RST = 1'b0;
        repeat (3) @(negedge REC_CLK);
        ABORT = 1'b1;
        @(negedge REC_CLK);
        ABORT = 1'b0;
        repeat (12) @(negedge REC_CLK);
        chk("idle_quiet_busy", BUSY, 0);
        chk("idle_quiet_done", DONE, 0);

        plan_clear();
        do_run(1000, 0, 7, -1, lat);
        plan_clear();
        plan_m[17] = 1'b0; plan_m[400] = 1'b0; plan_m[999] = 1'b0;
        do_run(1000, 0, 2, -1, lat);
        do_run(1000, 3, 9, -1, lat);
        plan_clear();
        do_run(1000, 0, 5000, -1, lat);
        chk("tmo_latency_in_window", (lat >= TMO_LAT + 1) && (lat <= TMO_LAT + 4), 1);
        plan_clear();
        plan_v[500] = 1'b0;
        do_run(1000, 0, 4, -1, lat);
        plan_clear();
        plan_m[3] = 1'b0; plan_m[8] = 1'b0;
        do_run(1000, 5, 6, 6 + 12, lat);
        plan_clear();
        for (int i = 0; i < PLAN_N; i++) plan_m[i] = 1'b0;
        do_run(40, 0, 1, -1, lat);
        do_run(40, 15, 3, -1, lat);
        plan_clear();
        do_run(0, 0, 2, -1, lat);

        // Reset in the middle of a run
        plan_clear();
        plan_d = 3;
        RUN_LEN = 1000;
        ERR_THR = 0;
        @(negedge REC_CLK);
        START = 1'b1;
        @(negedge REC_CLK);
        START = 1'b0;
        wait_k(50, ok);
        chk("midrun_reached", ok, 1);
        @(negedge REC_CLK);
        RST = 1'b1;
        #1;
        reset_checks();
        @(negedge REC_CLK);
        RST = 1'b0;
        repeat (8) @(negedge REC_CLK);
        chk("post_rst_idle", BUSY || DONE, 0);

        for (int r = 0; r < 25; r++) begin
            plan_clear();
            rl  = $urandom_range(0, 80);
            tgt = (rl == 0) ? 1 : rl;
            thr = $urandom_range(0, 4);
            d   = $urandom_range(0, 30);
            for (int i = 0; i < tgt; i++) plan_m[i] = ($urandom_range(0, 7) != 0);
            li = tgt;
            if (tgt > 1 && $urandom_range(0, 3) == 0) begin
                li = $urandom_range(1, tgt - 1);
                plan_v[li] = 1'b0;
            end
            ab = -1;
            if (d + li - 1 >= 1 && $urandom_range(0, 4) == 0) ab = $urandom_range(1, d + li - 1);
            do_run(rl, thr, d, ab, lat);
        end

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge REC_CLK);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d runs left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
